// File: rtl/repack_arbiter_if.sv
// rtl/repack_arbiter_if.sv - requester-side and repack-side handshake bundle for repack_arbiter
interface repack_arbiter_if #(
    parameter int N = 2,
    parameter int W = 8
) ();
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   s_stb;
    logic [N*W-1:0] s_dat;
    logic [N-1:0]   s_rdy;
    logic           m_stb;
    logic [W-1:0]   m_dat;
    logic           m_rdy;
    logic [IW-1:0]  m_id;
    logic           busy;

    // arbiter side
    modport master (
        input  s_stb, s_dat, m_rdy,
        output s_rdy, m_stb, m_dat, m_id, busy
    );

    // environment side: requesters plus the downstream repack stage
    modport slave (
        output s_stb, s_dat, m_rdy,
        input  s_rdy, m_stb, m_dat, m_id, busy
    );
endinterface

// File: rtl/repack_arbiter.sv
// rtl/repack_arbiter.sv - grant-locked round-robin arbiter feeding one repack stage; REPACK_ARBITER_FIXED_PRIO_EN selects fixed priority
module repack_arbiter #(
    parameter int N = 2,
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    repack_arbiter_if.master bus
);
    localparam int GW = $clog2(N);
    localparam int CW = $clog2(D);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state;
    logic [GW-1:0]  gnt;
    logic [GW-1:0]  win;
    logic [CW-1:0]  cnt;
    logic           found;
    logic           accept;
`ifndef REPACK_ARBITER_FIXED_PRIO_EN
    logic [GW-1:0]  last;
    logic [GW-1:0]  idx;
`endif

    assign accept   = (state == LOCK) && bus.m_stb && bus.m_rdy;
    assign bus.m_id = gnt;
    assign bus.busy = (state == LOCK);

    // winner search among current strobes; only consumed in IDLE
    always_comb begin
        win   = '0;
        found = 1'b0;
`ifdef REPACK_ARBITER_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) begin
            if (!found && bus.s_stb[k]) begin
                win   = GW'(k);
                found = 1'b1;
            end
        end
`else
        idx = '0;
        for (int k = 1; k <= N; k++) begin
            // explicit wrap so non-power-of-two N never indexes past N-1
            if (int'(last) + k >= N) begin
                idx = GW'(int'(last) + k - N);
            end else begin
                idx = GW'(int'(last) + k);
            end
            if (!found && bus.s_stb[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
`endif
    end

    // steer the granted requester onto the repack port; idle drives zeros
    always_comb begin
        bus.m_stb = 1'b0;
        bus.m_dat = '0;
        bus.s_rdy = '0;
        if (state == LOCK) begin
            bus.m_stb      = bus.s_stb[gnt];
            bus.m_dat      = bus.s_dat[int'(gnt)*W +: W];
            bus.s_rdy[gnt] = bus.m_rdy;
        end
    end

    // grant FSM: lock one requester for exactly D accepted beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
`ifndef REPACK_ARBITER_FIXED_PRIO_EN
            last  <= GW'(N - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= win;
                        cnt   <= '0;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        if (cnt == CW'(D - 1)) begin
                            cnt   <= '0;
`ifndef REPACK_ARBITER_FIXED_PRIO_EN
                            last  <= gnt;
`endif
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_repack_arbiter.sv
// tb/tb_repack_arbiter.sv - self-checking bench for repack_arbiter with requester models and beat scoreboard
module tb_repack_arbiter;
    localparam int N = 2;
    localparam int W = 8;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    repack_arbiter_if #(.N(N), .W(W)) bus ();
    repack_arbiter #(.N(N), .W(W), .D(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          checks = 0;
    int          fails  = 0;
    logic [7:0]  src[N][$];
    logic [15:0] exp_q[$];
    logic [15:0] got_w[$];
    logic [N-1:0] en = '1;
    logic        sb_en = 1'b0;
    int          pc = 0;
    logic [15:0] pk = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] d);
        exp_q.push_back({8'(id), d});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) src[i].delete();
        exp_q.delete();
        got_w.delete();
        pc = 0;
        en = '1;
        bus.m_rdy = 1'b1;
        rst_n = 1'b1;
        sb_en = 1'b1;
    endtask

    // requester models plus accepted-beat monitor and packing model
    initial begin : drv
        logic [N-1:0] acc;
        logic [15:0]  e;
        bus.s_stb = '0;
        bus.s_dat = '0;
        forever begin
            @(negedge clk);
            acc = bus.s_stb & bus.s_rdy;
            if (sb_en && bus.m_stb && bus.m_rdy) begin
                chk("sb_beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_id", 32'(bus.m_id), 32'(e[15:8]));
                    chk("sb_dat", 32'(bus.m_dat), 32'(e[7:0]));
                end
                pk[8*pc +: 8] = bus.m_dat;
                pc++;
                if (pc == D) begin
                    got_w.push_back(pk);
                    pc = 0;
                end
            end
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
                bus.s_stb[i]       = en[i] && (src[i].size() > 0);
                bus.s_dat[W*i +: W] = (src[i].size() > 0) ? src[i][0] : 8'h00;
            end
        end
    end

    initial begin : main
        int gid[4];
        int ia;
        int ib;
        logic [7:0] d;
        bit pat[6];
        pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef REPACK_ARBITER_FIXED_PRIO_EN
        gid = '{0, 0, 1, 1};
`else
        gid = '{0, 1, 0, 1};
`endif
        rst_n = 1'b0;
        bus.m_rdy = 1'b1;

        // reset values
        #12;
        chk("rst_m_stb", 32'(bus.m_stb), 32'd0);
        chk("rst_s_rdy", 32'(bus.s_rdy), 32'd0);
        chk("rst_m_dat", 32'(bus.m_dat), 32'd0);
        chk("rst_m_id",  32'(bus.m_id),  32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);

        // single requester, four beats, two packed words
        do_reset();
        for (int k = 0; k < 4; k++) begin
            d = 8'(17 * (k + 1));
            src[0].push_back(d);
            push_exp(0, d);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t1_m_stb", 32'(bus.m_stb), 32'(pat[c]));
            chk("t1_m_id", 32'(bus.m_id), 32'd0);
        end
        @(posedge clk); #1;
        chk("t1_words", 32'(got_w.size()), 32'd2);
        if (got_w.size() == 2) begin
            chk("t1_word0", 32'(got_w[0]), 32'h2211);
            chk("t1_word1", 32'(got_w[1]), 32'h4433);
        end
        chk("t1_drain", 32'(exp_q.size()), 32'd0);

        // both requesters continuously
        do_reset();
        for (int k = 0; k < 4; k++) begin
            src[0].push_back(8'(8'hA0 + k));
            src[1].push_back(8'(8'hB0 + k));
        end
        ia = 0;
        ib = 0;
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 2; b++) begin
                if (gid[g] == 0) begin
                    push_exp(0, 8'(8'hA0 + ia));
                    ia++;
                end else begin
                    push_exp(1, 8'(8'hB0 + ib));
                    ib++;
                end
            end
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("t2_busy", 32'(bus.busy), 32'((c % 3) != 0));
            if ((c % 3) != 0) chk("t2_m_id", 32'(bus.m_id), 32'(gid[(c-1)/3]));
`ifdef REPACK_ARBITER_FIXED_PRIO_EN
            if (c < 6) chk("t2_s_rdy1_never", 32'(bus.s_rdy[1]), 32'd0);
`endif
        end
        @(posedge clk); #1;
        chk("t2_drain", 32'(exp_q.size()), 32'd0);

        // backpressure for 3 cycles mid-group
        do_reset();
        src[0].push_back(8'h55); push_exp(0, 8'h55);
        src[0].push_back(8'h66); push_exp(0, 8'h66);
        @(negedge clk);
        chk("t3_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("t3_beat0_stb", 32'(bus.m_stb), 32'd1);
        chk("t3_beat0_rdy", 32'(bus.s_rdy), 32'd1);
        @(posedge clk); #1;
        bus.m_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t3_stall_stb", 32'(bus.m_stb), 32'd1);
            chk("t3_stall_rdy", 32'(bus.s_rdy), 32'd0);
            chk("t3_stall_dat", 32'(bus.m_dat), 32'h66);
            chk("t3_stall_busy", 32'(bus.busy), 32'd1);
        end
        @(posedge clk); #1;
        bus.m_rdy = 1'b1;
        @(negedge clk);
        chk("t3_beat1_rdy", 32'(bus.s_rdy), 32'd1);
        chk("t3_beat1_dat", 32'(bus.m_dat), 32'h66);
        @(negedge clk);
        chk("t3_done", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        chk("t3_drain", 32'(exp_q.size()), 32'd0);

        // granted requester drops strobe mid-group while the other waits
        do_reset();
        src[0].push_back(8'hC0); push_exp(0, 8'hC0);
        src[0].push_back(8'hC1); push_exp(0, 8'hC1);
        src[1].push_back(8'hD0);
        src[1].push_back(8'hD1);
        push_exp(1, 8'hD0);
        push_exp(1, 8'hD1);
        @(negedge clk);
        @(negedge clk);
        chk("t4_beat0_id", 32'(bus.m_id), 32'd0);
        chk("t4_beat0_dat", 32'(bus.m_dat), 32'hC0);
        @(posedge clk); #1;
        en = 2'b10;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t4_gap_stb", 32'(bus.m_stb), 32'd0);
            chk("t4_gap_id", 32'(bus.m_id), 32'd0);
            chk("t4_gap_rdy1", 32'(bus.s_rdy[1]), 32'd0);
            chk("t4_gap_busy", 32'(bus.busy), 32'd1);
        end
        @(posedge clk); #1;
        en = '1;
        @(negedge clk);
        chk("t4_beat1_stb", 32'(bus.m_stb), 32'd1);
        chk("t4_beat1_dat", 32'(bus.m_dat), 32'hC1);
        @(negedge clk);
        chk("t4_bubble", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("t4_r1_busy", 32'(bus.busy), 32'd1);
        chk("t4_r1_id", 32'(bus.m_id), 32'd1);
        @(negedge clk);
        @(posedge clk); #1;
        chk("t4_drain", 32'(exp_q.size()), 32'd0);

        // asynchronous reset mid-group, then requester 0 first
        do_reset();
        sb_en = 1'b0;
        src[1].push_back(8'hF0);
        src[1].push_back(8'hF1);
        @(negedge clk);
        @(negedge clk);
        chk("t5_locked_id", 32'(bus.m_id), 32'd1);
        chk("t5_locked_stb", 32'(bus.m_stb), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_m_stb", 32'(bus.m_stb), 32'd0);
        chk("t5_rst_s_rdy", 32'(bus.s_rdy), 32'd0);
        chk("t5_rst_m_dat", 32'(bus.m_dat), 32'd0);
        chk("t5_rst_m_id",  32'(bus.m_id),  32'd0);
        chk("t5_rst_busy",  32'(bus.busy),  32'd0);
        do_reset();
        src[0].push_back(8'hE0); push_exp(0, 8'hE0);
        src[0].push_back(8'hE1); push_exp(0, 8'hE1);
        src[1].push_back(8'hF0);
        src[1].push_back(8'hF1);
        push_exp(1, 8'hF0);
        push_exp(1, 8'hF1);
        @(negedge clk);
        chk("t5_post_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("t5_post_busy", 32'(bus.busy), 32'd1);
        chk("t5_post_id", 32'(bus.m_id), 32'd0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        chk("t5_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
